reg_writeback_port: RTL and testbench

- Write-side master for the register file. Drives its `we`/`addressW`/`data` write port from two producers:
  - the MEM/WB pipeline result, which has priority;
  - a long-latency unit result (mult/div), delivered over a valid/ready handshake with a 1-entry holding buffer.
- Supplies same-cycle write-before-read forwarding to the decode stage.
- Sits between the MEM/WB latch and the register file.

---
 rtl/reg_writeback_port.sv | 110 +++++++++++
 tb/tb_reg_writeback_port.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_port.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_port
// Brief    : Register-file write master merging MEM/WB and long-unit results,
//            with a 1-entry holding buffer and write-before-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback_port #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_valid,
    input  logic                     pipe_regWrite,
    input  logic                     pipe_memToReg,
    input  logic [DATA_WIDTH-1:0]    pipe_aluResult,
    input  logic [DATA_WIDTH-1:0]    pipe_memData,
    input  logic [ADDRESS_WIDTH-1:0] pipe_address,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [ADDRESS_WIDTH-1:0] lu_address,
    input  logic [DATA_WIDTH-1:0]    lu_data,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] addressW,
    output logic [DATA_WIDTH-1:0]    data,
    input  logic [ADDRESS_WIDTH-1:0] fwdAddressA,
    input  logic [ADDRESS_WIDTH-1:0] fwdAddressB,
    output logic                     fwdHitA,
    output logic                     fwdHitB,
    output logic [DATA_WIDTH-1:0]    fwdDataA,
    output logic [DATA_WIDTH-1:0]    fwdDataB,
    output logic                     pending
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } bufState_t;

    bufState_t                r_state;
    logic [ADDRESS_WIDTH-1:0] r_heldAddress;
    logic [DATA_WIDTH-1:0]    r_heldData;

    logic                     w_pipeReq;
    logic [DATA_WIDTH-1:0]    w_pipeValue;
    logic                     w_luFire;
    logic                     w_luNonZero;
    logic                     w_writeValid;

    assign w_pipeReq    = pipe_valid & pipe_regWrite & (pipe_address != '0);
    assign w_pipeValue  = pipe_memToReg ? pipe_memData : pipe_aluResult;
    assign pending      = (r_state == HELD);
    assign lu_ready     = reset & ~pending;
    assign w_luFire     = lu_valid & lu_ready;
    assign w_luNonZero  = (lu_address != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= EMPTY;
            r_heldAddress <= '0;
            r_heldData    <= '0;
            we            <= 1'b0;
            addressW      <= '0;
            data          <= '0;
        end else begin
            // Issue priority: pipe, then held entry, then a direct long-unit write
            we <= 1'b0;
            if (w_pipeReq) begin
                we       <= 1'b1;
                addressW <= pipe_address;
                data     <= w_pipeValue;
            end else if (r_state == HELD) begin
                we       <= 1'b1;
                addressW <= r_heldAddress;
                data     <= r_heldData;
            end else if (w_luFire && w_luNonZero) begin
                we       <= 1'b1;
                addressW <= lu_address;
                data     <= lu_data;
            end

            case (r_state)
                EMPTY: begin
                    // A long-unit result aimed at the pipe's destination is stale; drop it
                    if (w_luFire && w_pipeReq && w_luNonZero &&
                        (lu_address != pipe_address)) begin
                        r_state       <= HELD;
                        r_heldAddress <= lu_address;
                        r_heldData    <= lu_data;
                    end
                end
                HELD: begin
                    if (!w_pipeReq || (pipe_address == r_heldAddress)) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign w_writeValid = we & (addressW != '0);
    assign fwdHitA      = w_writeValid & (fwdAddressA == addressW);
    assign fwdHitB      = w_writeValid & (fwdAddressB == addressW);
    assign fwdDataA     = fwdHitA ? data : '0;
    assign fwdDataB     = fwdHitB ? data : '0;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_port
// Brief    : Directed self-checking bench for reg_writeback_port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_port;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          pipe_valid;
    logic          pipe_regWrite;
    logic          pipe_memToReg;
    logic [DW-1:0] pipe_aluResult;
    logic [DW-1:0] pipe_memData;
    logic [AW-1:0] pipe_address;
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_address;
    logic [DW-1:0] lu_data;
    logic          we;
    logic [AW-1:0] addressW;
    logic [DW-1:0] data;
    logic [AW-1:0] fwdAddressA;
    logic [AW-1:0] fwdAddressB;
    logic          fwdHitA;
    logic          fwdHitB;
    logic [DW-1:0] fwdDataA;
    logic [DW-1:0] fwdDataB;
    logic          pending;

    int checks;
    int failures;

    reg_writeback_port #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_valid     (pipe_valid),
        .pipe_regWrite  (pipe_regWrite),
        .pipe_memToReg  (pipe_memToReg),
        .pipe_aluResult (pipe_aluResult),
        .pipe_memData   (pipe_memData),
        .pipe_address   (pipe_address),
        .lu_valid       (lu_valid),
        .lu_ready       (lu_ready),
        .lu_address     (lu_address),
        .lu_data        (lu_data),
        .we             (we),
        .addressW       (addressW),
        .data           (data),
        .fwdAddressA    (fwdAddressA),
        .fwdAddressB    (fwdAddressB),
        .fwdHitA        (fwdHitA),
        .fwdHitB        (fwdHitB),
        .fwdDataA       (fwdDataA),
        .fwdDataB       (fwdDataB),
        .pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setPipe(input logic v, input logic rw, input logic m2r,
                           input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                           input logic [AW-1:0] addr);
        pipe_valid     = v;
        pipe_regWrite  = rw;
        pipe_memToReg  = m2r;
        pipe_aluResult = alu;
        pipe_memData   = mem;
        pipe_address   = addr;
    endtask

    task automatic setLu(input logic v, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        lu_valid   = v;
        lu_address = addr;
        lu_data    = d;
    endtask

    task automatic idle();
        setPipe(1'b0, 1'b0, 1'b0, '0, '0, '0);
        setLu(1'b0, '0, '0);
    endtask

    task automatic test_reset();
        checks++;
        if (we !== 1'b0 || addressW !== '0 || data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: we=%b addressW=%0d data=%h required 0/0/0", we, addressW, data);
        end
        checks++;
        if (pending !== 1'b0 || lu_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: pending=%b lu_ready=%b required 0/0", pending, lu_ready);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (lu_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: lu_ready=%b required 1", lu_ready);
        end
    endtask

    task automatic test_async_reset_held();
        setPipe(1'b1, 1'b1, 1'b0, 32'h33, '0, 5'd3);
        setLu(1'b1, 5'd5, 32'h5);
        tick();
        idle();
        checks++;
        if (pending !== 1'b1 || we !== 1'b1) begin
            failures++;
            $display("FAIL async_setup_held: pending=%b we=%b required 1/1", pending, we);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || addressW !== '0 || data !== '0 || pending !== 1'b0 || lu_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: we=%b addressW=%0d data=%h pending=%b lu_ready=%b required all 0",
                     we, addressW, data, pending, lu_ready);
        end
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (lu_ready !== 1'b1 || pending !== 1'b0) begin
            failures++;
            $display("FAIL async_release: lu_ready=%b pending=%b required 1/0", lu_ready, pending);
        end
        tick();
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL async_no_stale_write: we=%b required 0", we);
        end
    endtask

    task automatic test_pipe_write_fwd();
        setPipe(1'b1, 1'b1, 1'b0, 32'hF, 32'hDEAD, 5'd2);
        tick();
        idle();
        fwdAddressA = 5'd2;
        fwdAddressB = 5'd3;
        #1;
        checks++;
        if (we !== 1'b1 || addressW !== 5'd2 || data !== 32'hF) begin
            failures++;
            $display("FAIL pipe_write: we=%b addressW=%0d data=%h required 1/2/0000000f", we, addressW, data);
        end
        checks++;
        if (fwdHitA !== 1'b1 || fwdDataA !== 32'hF) begin
            failures++;
            $display("FAIL fwd_hitA: hit=%b data=%h required 1/0000000f", fwdHitA, fwdDataA);
        end
        checks++;
        if (fwdHitB !== 1'b0 || fwdDataB !== '0) begin
            failures++;
            $display("FAIL fwd_missB: hit=%b data=%h required 0/00000000", fwdHitB, fwdDataB);
        end
        tick();
        checks++;
        if (we !== 1'b0 || fwdHitA !== 1'b0) begin
            failures++;
            $display("FAIL pipe_idle: we=%b fwdHitA=%b required 0/0", we, fwdHitA);
        end
    endtask

    task automatic test_capture_drain();
        setPipe(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'h8, 5'd3);
        setLu(1'b1, 5'd5, 32'h5);
        #1;
        checks++;
        if (lu_ready !== 1'b1) begin
            failures++;
            $display("FAIL capture_ready_pre: lu_ready=%b required 1", lu_ready);
        end
        tick();
        idle();
        checks++;
        if (we !== 1'b1 || addressW !== 5'd3 || data !== 32'h8 || pending !== 1'b1 || lu_ready !== 1'b0) begin
            failures++;
            $display("FAIL capture_first: we=%b addressW=%0d data=%h pending=%b lu_ready=%b required 1/3/8/1/0",
                     we, addressW, data, pending, lu_ready);
        end
        tick();
        checks++;
        if (we !== 1'b1 || addressW !== 5'd5 || data !== 32'h5 || pending !== 1'b0 || lu_ready !== 1'b1) begin
            failures++;
            $display("FAIL capture_drain: we=%b addressW=%0d data=%h pending=%b lu_ready=%b required 1/5/5/0/1",
                     we, addressW, data, pending, lu_ready);
        end
        tick();
    endtask

    task automatic test_supersede();
        setPipe(1'b1, 1'b1, 1'b0, 32'h44, '0, 5'd3);
        setLu(1'b1, 5'd5, 32'h5);
        tick();
        setLu(1'b0, '0, '0);
        setPipe(1'b1, 1'b1, 1'b0, 32'hA, '0, 5'd5);
        tick();
        idle();
        checks++;
        if (we !== 1'b1 || addressW !== 5'd5 || data !== 32'hA || pending !== 1'b0) begin
            failures++;
            $display("FAIL supersede_write: we=%b addressW=%0d data=%h pending=%b required 1/5/a/0",
                     we, addressW, data, pending);
        end
        tick();
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL supersede_no_stale: we=%b addressW=%0d data=%h required we=0", we, addressW, data);
        end
    endtask

    task automatic test_reg_zero();
        setPipe(1'b1, 1'b1, 1'b0, 32'h55, '0, 5'd0);
        fwdAddressA = 5'd0;
        tick();
        idle();
        #1;
        checks++;
        if (we !== 1'b0 || fwdHitA !== 1'b0) begin
            failures++;
            $display("FAIL zero_pipe: we=%b fwdHitA=%b required 0/0", we, fwdHitA);
        end
        setLu(1'b1, 5'd0, 32'h9);
        #1;
        checks++;
        if (lu_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_lu_ready: lu_ready=%b required 1", lu_ready);
        end
        tick();
        idle();
        checks++;
        if (we !== 1'b0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL zero_lu: we=%b pending=%b required 0/0", we, pending);
        end
        // Zero-destination lu result alongside a pipe write must not be held either
        setPipe(1'b1, 1'b1, 1'b0, 32'h66, '0, 5'd6);
        setLu(1'b1, 5'd0, 32'h9);
        tick();
        idle();
        checks++;
        if (we !== 1'b1 || addressW !== 5'd6 || pending !== 1'b0) begin
            failures++;
            $display("FAIL zero_lu_with_pipe: we=%b addressW=%0d pending=%b required 1/6/0", we, addressW, pending);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int r7Writes;
        int readyHigh;
        r7Writes  = 0;
        readyHigh = 0;
        setLu(1'b1, 5'd7, 32'h7);
        for (int i = 0; i < 4; i++) begin
            setPipe(1'b1, 1'b1, 1'b0, 32'h10 + DW'(i), '0, AW'(10 + i));
            #1;
            if (i > 0 && lu_ready !== 1'b0) readyHigh++;
            tick();
            if (i == 0) setLu(1'b0, '0, '0);
            if (we === 1'b1 && addressW === 5'd7) r7Writes++;
            checks++;
            if (we !== 1'b1 || addressW !== AW'(10 + i) || data !== 32'h10 + DW'(i)) begin
                failures++;
                $display("FAIL b2b_pipe%0d: we=%b addressW=%0d data=%h required 1/%0d/%h",
                         i, we, addressW, data, 10 + i, 32'h10 + i);
            end
        end
        idle();
        checks++;
        if (readyHigh != 0 || pending !== 1'b1) begin
            failures++;
            $display("FAIL b2b_backpressure: readyHighCycles=%0d pending=%b required 0/1", readyHigh, pending);
        end
        tick();
        if (we === 1'b1 && addressW === 5'd7) r7Writes++;
        checks++;
        if (we !== 1'b1 || addressW !== 5'd7 || data !== 32'h7 || pending !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: we=%b addressW=%0d data=%h pending=%b required 1/7/7/0",
                     we, addressW, data, pending);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (we === 1'b1 && addressW === 5'd7) r7Writes++;
        end
        checks++;
        if (r7Writes != 1) begin
            failures++;
            $display("FAIL b2b_once: r7 writes=%0d required 1", r7Writes);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        fwdAddressA = '0;
        fwdAddressB = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        tick();
        test_async_reset_held();
        test_pipe_write_fwd();
        test_capture_drain();
        test_supersede();
        test_reg_zero();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
